mem_arbiter_ctrl: RTL and testbench

Shared single-port word memory serving NPORTS requesters (e.g. port 0 = instruction fetch, port 1 = load/store) through per-port valid/ready request channels. Arbitration is round-robin. Writes use byte enables. Every accepted request returns exactly one response after a fixed RD_LATENCY. It replaces the separate imem/dmem instances at the processor top level with one arbitrated storage.

---
 rtl/mem_arbiter_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbitrated single-port word memory with byte-enabled writes and a fixed-latency response pipeline.
// Optional access/stall statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter_ctrl #(
    parameter int    WIDTH      = 32,
    parameter int    ADDR       = 5,
    parameter int    NPORTS     = 2,
    parameter int    RD_LATENCY = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORTS-1:0]             req_valid,
    output logic [NPORTS-1:0]             req_ready,
    input  logic [NPORTS-1:0]             req_wr_en,
    input  logic [NPORTS*ADDR-1:0]        req_addr,
    input  logic [NPORTS*WIDTH-1:0]       req_wdata,
    input  logic [NPORTS*(WIDTH/8)-1:0]   req_be,
    output logic [NPORTS-1:0]             rsp_valid,
    output logic [WIDTH-1:0]              rsp_rdata,
    output logic [31:0]                   stat_reads,
    output logic [31:0]                   stat_writes,
    output logic [31:0]                   stat_stalls
);

    localparam int DEPTH  = 2 ** ADDR;
    localparam int NBYTES = WIDTH / 8;
    localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     cand;
    logic [PW-1:0]     grant_idx;
    logic              grant_valid;
    logic              accept;

    logic              sel_wr;
    logic [ADDR-1:0]   sel_addr;
    logic [WIDTH-1:0]  sel_wdata;
    logic [NBYTES-1:0] sel_be;

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [PW-1:0]         pipe_port [RD_LATENCY];
    logic [WIDTH-1:0]      pipe_data [RD_LATENCY];

    // First valid port at or after rr_ptr (wrapping) wins; nothing is granted during reset.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NPORTS; k++) begin
            cand = PW'((int'(rr_ptr) + k) % NPORTS);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (reset) grant_valid = 1'b0;
    end

    assign accept    = grant_valid;
    assign req_ready = grant_valid ? (NPORTS'(1) << grant_idx) : '0;

    assign sel_wr    = req_wr_en[grant_idx];
    assign sel_addr  = req_addr[grant_idx*ADDR +: ADDR];
    assign sel_wdata = req_wdata[grant_idx*WIDTH +: WIDTH];
    assign sel_be    = req_be[grant_idx*NBYTES +: NBYTES];

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            if (grant_idx == PW'(NPORTS - 1)) rr_ptr <= '0;
            else                              rr_ptr <= grant_idx + PW'(1);
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && sel_wr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (sel_be[b]) mem[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                pipe_port[s] <= '0;
                pipe_data[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_port[0]  <= grant_idx;
            pipe_data[0]  <= (accept && !sel_wr) ? mem[sel_addr] : '0;
            for (int s = 1; s < RD_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_port[s]  <= pipe_port[s-1];
                pipe_data[s]  <= pipe_data[s-1];
            end
        end
    end

    assign rsp_valid = pipe_valid[RD_LATENCY-1] ? (NPORTS'(1) << pipe_port[RD_LATENCY-1]) : '0;
    assign rsp_rdata = pipe_valid[RD_LATENCY-1] ? pipe_data[RD_LATENCY-1] : '0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] cnt_reads;
    logic [31:0] cnt_writes;
    logic [31:0] cnt_stalls;

    // A stall is any cycle where some requesting port goes ungranted, even if another port wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reads  <= '0;
            cnt_writes <= '0;
            cnt_stalls <= '0;
        end else begin
            if (accept && !sel_wr)             cnt_reads  <= cnt_reads + 32'd1;
            if (accept && sel_wr)              cnt_writes <= cnt_writes + 32'd1;
            if (|(req_valid & ~req_ready))     cnt_stalls <= cnt_stalls + 32'd1;
        end
    end

    assign stat_reads  = cnt_reads;
    assign stat_writes = cnt_writes;
    assign stat_stalls = cnt_stalls;
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: table-driven grants plus a response scoreboard
// fed from a bench-side memory model; stats expectations follow MEM_ARB_STATS_EN.
module tb_mem_arbiter_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr_en = '0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
    logic [31:0] stat_stalls;

    mem_arbiter_ctrl #(
        .WIDTH(32), .ADDR(5), .NPORTS(2), .RD_LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr_en(req_wr_en),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_stalls(stat_stalls)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  valid;
        logic [1:0]  wr;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  be0, be1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] model_mem [32];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] exp_reads = 0, exp_writes = 0, exp_stalls = 0;
    vec_t        tbl [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] valid, input logic [1:0] wr,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] be0, input logic [3:0] be1,
                                input logic [1:0] rdy);
        vec_t v;
        v.name = n; v.valid = valid; v.wr = wr; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.be0 = be0; v.be1 = be1; v.exp_ready = rdy;
        return v;
    endfunction

    // Drive one cycle, check the grant, then update the reference model at the edge.
    task automatic applyStimulus(input vec_t v);
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        rsp_t        r;
        @(negedge clk);
        #1;
        req_valid = v.valid;
        req_wr_en = v.wr;
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        req_be    = {v.be1, v.be0};
        #1;
        checkOutput({v.name, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
        @(posedge clk);
        cyc++;
        if (|(v.valid & ~v.exp_ready)) exp_stalls++;
        for (int p = 0; p < 2; p++) begin
            if (v.exp_ready[p]) begin
                a  = (p == 0) ? v.a0  : v.a1;
                d  = (p == 0) ? v.d0  : v.d1;
                be = (p == 0) ? v.be0 : v.be1;
                r.due  = cyc + LAT - 1;
                r.port = p;
                if (v.wr[p]) begin
                    r.data = 32'h0;
                    exp_writes++;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
                end else begin
                    r.data = model_mem[a];
                    exp_reads++;
                end
                sb.push_back(r);
            end
        end
    endtask

    task automatic applyReset(input logic [1:0] valid);
        @(negedge clk);
        #1;
        reset     = 1'b1;
        req_valid = valid;
        req_wr_en = 2'b00;
        #1;
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        cyc++;
        sb.delete();
        exp_reads = 0; exp_writes = 0; exp_stalls = 0;
        #1;
        reset     = 1'b0;
        req_valid = 2'b00;
        mon_en    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(mk("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
    endtask

    task automatic checkStats(input string tag);
        logic [31:0] er, ew, es;
`ifdef MEM_ARB_STATS_EN
        er = exp_reads; ew = exp_writes; es = exp_stalls;
`else
        er = 0; ew = 0; es = 0;
`endif
        checkOutput({tag, "_stat_reads"},  stat_reads,  er);
        checkOutput({tag, "_stat_writes"}, stat_writes, ew);
        checkOutput({tag, "_stat_stalls"}, stat_stalls, es);
    endtask

    // Response monitor: exactly one pulse per scoreboard entry, idle zeros otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << sb[0].port);
                checkOutput("rsp_rdata", rsp_rdata, sb[0].data);
                void'(sb.pop_front());
            end else begin
                checkOutput("rsp_idle_valid", 32'(rsp_valid), 32'h0);
                checkOutput("rsp_idle_rdata", rsp_rdata, 32'h0);
            end
        end
    end

    initial begin
        tbl[0]  = mk("wr5_p1",     2'b10, 2'b10, 0, 5,  0, 32'hDEADBEEF, 0, 4'hF, 2'b10);
        tbl[1]  = mk("rd5_p1",     2'b10, 2'b00, 0, 5,  0, 0,            0, 0,    2'b10);
        tbl[2]  = mk("wr3_full",   2'b01, 2'b01, 3, 0,  32'h11223344, 0, 4'hF, 0, 2'b01);
        tbl[3]  = mk("wr3_be0101", 2'b01, 2'b01, 3, 0,  32'hAABBCCDD, 0, 4'b0101, 0, 2'b01);
        tbl[4]  = mk("rd3_p1",     2'b10, 2'b00, 0, 3,  0, 0,            0, 0,    2'b10);
        tbl[5]  = mk("wr7_rd7",    2'b11, 2'b01, 7, 7,  32'hCAFEF00D, 0, 4'hF, 0, 2'b01);
        tbl[6]  = mk("rd7_p1",     2'b10, 2'b00, 0, 7,  0, 0,            0, 0,    2'b10);
        tbl[7]  = mk("wr31_p0",    2'b01, 2'b01, 31, 0, 32'h000000FF, 0, 4'hF, 0, 2'b01);
        tbl[8]  = mk("be0_p1",     2'b11, 2'b10, 31, 0, 0, 32'hFFFFFFFF, 0, 4'h0, 2'b10);
        tbl[9]  = mk("rd31_p0",    2'b01, 2'b00, 31, 0, 0, 0,            0, 0,    2'b01);
        tbl[10] = mk("idle_tbl",   2'b00, 2'b00, 0, 0,  0, 0,            0, 0,    2'b00);
        tbl[11] = mk("rr_p1",      2'b11, 2'b00, 31, 5, 0, 0,            0, 0,    2'b10);
        tbl[12] = mk("rr_p0",      2'b11, 2'b00, 31, 3, 0, 0,            0, 0,    2'b01);

        applyReset(2'b11);
        checkStats("after_reset");

        for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);
        idle(LAT + 1);
        checkStats("table");

        // Strict rotation from reset with both ports always requesting.
        applyReset(2'b00);
        applyStimulus(mk("rot0", 2'b11, 2'b00, 5, 3, 0, 0, 0, 0, 2'b01));
        applyStimulus(mk("rot1", 2'b11, 2'b00, 5, 3, 0, 0, 0, 0, 2'b10));
        applyStimulus(mk("rot2", 2'b11, 2'b00, 7, 31, 0, 0, 0, 0, 2'b01));
        applyStimulus(mk("rot3", 2'b11, 2'b00, 7, 31, 0, 0, 0, 0, 2'b10));
        idle(LAT + 1);
        checkStats("rotation");

        // Reset while a read is in flight: response dropped, pointer back to 0, storage kept.
        applyStimulus(mk("wr9_p0", 2'b01, 2'b01, 9, 0, 32'h12345678, 0, 4'hF, 0, 2'b01));
        applyStimulus(mk("rd9_p0", 2'b01, 2'b00, 9, 0, 0, 0, 0, 0, 2'b01));
        applyReset(2'b11);
        applyStimulus(mk("post_rst_p0", 2'b11, 2'b00, 9, 9, 0, 0, 0, 0, 2'b01));
        applyStimulus(mk("post_rst_p1", 2'b10, 2'b00, 9, 9, 0, 0, 0, 0, 2'b10));
        idle(LAT + 1);
        checkStats("post_reset");

        checkOutput("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
